hb_up2_gain_ramp: RTL

Downstream stage of the interleaved half-band up-by-2 interpolator. Each clock it consumes the two phase outputs (phase 0 first in time, then phase 1) and the overflow flag. It applies a per-sample programmable gain with a soft mute/unmute ramp state machine, then rounds, saturates, and counts overflows. Its outputs feed the DAC/serializer interface.

---
 rtl/hb_up2_gain_ramp.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/hb_up2_gain_ramp.sv
// rtl/hb_up2_gain_ramp.sv - gain ramp, round/saturate and overflow count for the half-band up-by-2 output
module hb_up2_gain_ramp #(
    parameter int DIN_WIDTH  = 16,
    parameter int GAIN_WIDTH = 16,
    parameter int GAIN_FRAC  = 14,
    parameter int DOUT_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DIN_WIDTH-1:0]  din0,
    input  logic signed [DIN_WIDTH-1:0]  din1,
    input  logic                         din_ovf,
    input  logic                         enable,
    input  logic [GAIN_WIDTH-1:0]        gain,
    input  logic [GAIN_WIDTH-1:0]        ramp_step,
    input  logic                         ovf_cnt_clr,
    output logic [DOUT_WIDTH-1:0]        dout0,
    output logic [DOUT_WIDTH-1:0]        dout1,
    output logic                         dout_ovf,
    output logic [1:0]                   state,
    output logic [CNT_WIDTH-1:0]         ovf_cnt
);

    localparam int PW = DIN_WIDTH + GAIN_WIDTH + 1;
    localparam logic signed [PW:0] RND  = {{(PW+1-GAIN_FRAC){1'b0}}, 1'b1, {(GAIN_FRAC-1){1'b0}}};
    localparam logic signed [PW:0] MAXV = {{(PW+2-DOUT_WIDTH){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic signed [PW:0] MINV = {{(PW+2-DOUT_WIDTH){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_MUTE      = 2'd0,
        S_RAMP_UP   = 2'd1,
        S_ACTIVE    = 2'd2,
        S_RAMP_DOWN = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [GAIN_WIDTH-1:0]   g_q, g_d;
    logic [GAIN_WIDTH:0]     g_up;

    // One extra bit so the ramp-up sum never wraps past the target
    assign g_up = {1'b0, g_q} + {1'b0, ramp_step};

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        case (state_q)
            S_MUTE: begin
                g_d = '0;
                if (enable) state_d = S_RAMP_UP;
            end
            S_RAMP_UP: begin
                if (!enable) begin
                    state_d = S_RAMP_DOWN;
                end else if (ramp_step == '0 || g_up >= {1'b0, gain}) begin
                    g_d     = gain;
                    state_d = S_ACTIVE;
                end else begin
                    g_d = g_up[GAIN_WIDTH-1:0];
                end
            end
            S_ACTIVE: begin
                g_d = gain;
                if (!enable) state_d = S_RAMP_DOWN;
            end
            S_RAMP_DOWN: begin
                if (enable) begin
                    state_d = S_RAMP_UP;
                end else if (ramp_step == '0 || g_q <= ramp_step) begin
                    g_d     = '0;
                    state_d = S_MUTE;
                end else begin
                    g_d = g_q - ramp_step;
                end
            end
            default: begin
                state_d = S_MUTE;
                g_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_MUTE;
            g_q     <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
        end
    end

    assign state = state_q;

    logic signed [DIN_WIDTH-1:0] d0_s1, d1_s1;
    logic                        ovf_s1, ovf_s2;
    logic signed [PW-1:0]        d0_x, d1_x, g_x;
    logic signed [PW-1:0]        p0_s2, p1_s2;
    logic [DOUT_WIDTH:0]         rs0, rs1;

    assign d0_x = {{(PW-DIN_WIDTH){d0_s1[DIN_WIDTH-1]}}, d0_s1};
    assign d1_x = {{(PW-DIN_WIDTH){d1_s1[DIN_WIDTH-1]}}, d1_s1};
    assign g_x  = {{(PW-GAIN_WIDTH){1'b0}}, g_q};

    // Returns {clipped, value}: round half up, then clamp to the output range
    function automatic logic [DOUT_WIDTH:0] round_sat(input logic signed [PW-1:0] p);
        logic signed [PW:0] s;
        logic signed [PW:0] r;
        s = $signed({p[PW-1], p}) + RND;
        r = s >>> GAIN_FRAC;
        if (r > MAXV)
            round_sat = {1'b1, 1'b0, {(DOUT_WIDTH-1){1'b1}}};
        else if (r < MINV)
            round_sat = {1'b1, 1'b1, {(DOUT_WIDTH-1){1'b0}}};
        else
            round_sat = {1'b0, r[DOUT_WIDTH-1:0]};
    endfunction

    assign rs0 = round_sat(p0_s2);
    assign rs1 = round_sat(p1_s2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d0_s1    <= '0;
            d1_s1    <= '0;
            ovf_s1   <= 1'b0;
            p0_s2    <= '0;
            p1_s2    <= '0;
            ovf_s2   <= 1'b0;
            dout0    <= '0;
            dout1    <= '0;
            dout_ovf <= 1'b0;
        end else begin
            d0_s1    <= din0;
            d1_s1    <= din1;
            ovf_s1   <= din_ovf;
            p0_s2    <= d0_x * g_x;
            p1_s2    <= d1_x * g_x;
            ovf_s2   <= ovf_s1;
            dout0    <= rs0[DOUT_WIDTH-1:0];
            dout1    <= rs1[DOUT_WIDTH-1:0];
            dout_ovf <= ovf_s2 | rs0[DOUT_WIDTH] | rs1[DOUT_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_cnt <= '0;
        end else if (ovf_cnt_clr) begin
            ovf_cnt <= '0;
        end else if (dout_ovf && ovf_cnt != '1) begin
            ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

endmodule
